// File: rtl/wb_serial_pkg.sv
// ---------------------------------------------------------------------------
// wb_serial_pkg
// Shared constants and types for the serial-to-Wishbone debug bridge.
//   - Command opcodes and response bytes of the host byte protocol.
//   - Bridge state encoding.
//   - pick_byte(): selects one byte of a 32-bit word, MSB first (idx 0 = [31:24]).
// ---------------------------------------------------------------------------
package wb_serial_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_TMO  = 8'h54;  // 'T'
    localparam logic [7:0] RSP_ERR  = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        BUS   = 3'd3,
        RESP  = 3'd4,
        RDATA = 3'd5
    } state_t;

    // Byte idx of a word in wire order (MSB first).
    function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wb_serial_master.sv
// ---------------------------------------------------------------------------
// wb_serial_master
// Debug bridge: parses a host byte stream into single 32-bit Wishbone classic
// transfers and returns a response byte stream.
//   'W' a3 a2 a1 a0 d3 d2 d1 d0  -> write, response 'K' (or 'T' on timeout)
//   'R' a3 a2 a1 a0              -> read,  response 'K' d3 d2 d1 d0 (or 'T')
//   anything else                -> response '?'
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, async active-low reset
//   rx_data_i/rx_valid_i/rx_ready_o   inbound byte stream (valid/ready)
//   tx_data_o/tx_valid_o/tx_ready_i   outbound byte stream (valid/ready)
//   wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o  Wishbone master
//   wb_ack_i, wb_dat_i          Wishbone slave response
//   busy_o                      high while a command is in progress
// All outputs come straight from registers; the output registers are loaded
// from the next-state decode so they line up with the state they belong to.
// ---------------------------------------------------------------------------
module wb_serial_master
    import wb_serial_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [3:0] SEL_ALL        = 4'hF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    output logic        busy_o
);

    // Counter value at which the cycle without ack is abandoned.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_r, state_s;
    logic [1:0]  cnt_r, cnt_s;
    logic        we_r, we_s;
    logic [31:0] adr_r, adr_s;
    logic [31:0] dat_r, dat_s;
    logic [31:0] rdata_r, rdata_s;
    logic [15:0] tmo_r, tmo_s;
    logic [7:0]  rsp_r, rsp_s;
    logic [7:0]  tx_data_r, tx_data_s;
    logic        rx_ready_r, tx_valid_r, cyc_r, busy_r;
    logic [3:0]  sel_r;
    logic        rx_fire_s, tx_fire_s;

    assign rx_fire_s = rx_valid_i && rx_ready_r;
    assign tx_fire_s = tx_valid_r && tx_ready_i;

    // Next-state, field shifting and response selection.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        we_s      = we_r;
        adr_s     = adr_r;
        dat_s     = dat_r;
        rdata_s   = rdata_r;
        tmo_s     = tmo_r;
        rsp_s     = rsp_r;
        tx_data_s = tx_data_r;
        case (state_r)
            IDLE: begin
                if (rx_fire_s) begin
                    if ((rx_data_i == OP_WRITE) || (rx_data_i == OP_READ)) begin
                        we_s    = (rx_data_i == OP_WRITE);
                        cnt_s   = 2'd0;
                        state_s = ADDR;
                    end else begin
                        rsp_s     = RSP_ERR;
                        tx_data_s = RSP_ERR;
                        state_s   = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (rx_fire_s) begin
                    adr_s = {adr_r[23:0], rx_data_i};
                    cnt_s = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        if (we_r) begin
                            cnt_s   = 2'd0;
                            state_s = DATA;
                        end else begin
                            tmo_s   = 16'd0;
                            state_s = BUS;
                        end
                    end else begin
                        state_s = ADDR;
                    end
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (rx_fire_s) begin
                    dat_s = {dat_r[23:0], rx_data_i};
                    cnt_s = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        tmo_s   = 16'd0;
                        state_s = BUS;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            BUS: begin
                // Ack is checked first so an ack on the limit cycle still wins.
                if (wb_ack_i) begin
                    if (!we_r) begin
                        rdata_s = wb_dat_i;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    rsp_s     = RSP_OK;
                    tx_data_s = RSP_OK;
                    state_s   = RESP;
                end else if (tmo_r == TMO_LAST) begin
                    rsp_s     = RSP_TMO;
                    tx_data_s = RSP_TMO;
                    state_s   = RESP;
                end else begin
                    tmo_s = tmo_r + 16'd1;
                end
            end
            RESP: begin
                if (tx_fire_s) begin
                    if (!we_r && (rsp_r == RSP_OK)) begin
                        cnt_s     = 2'd0;
                        tx_data_s = pick_byte(rdata_r, 2'd0);
                        state_s   = RDATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = RESP;
                end
            end
            RDATA: begin
                if (tx_fire_s) begin
                    cnt_s = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        state_s = IDLE;
                    end else begin
                        tx_data_s = pick_byte(rdata_r, cnt_r + 2'd1);
                    end
                end else begin
                    state_s = RDATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_r    <= IDLE;
            cnt_r      <= 2'd0;
            we_r       <= 1'b0;
            adr_r      <= 32'h0000_0000;
            dat_r      <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
            tmo_r      <= 16'd0;
            rsp_r      <= 8'h00;
            tx_data_r  <= 8'h00;
            rx_ready_r <= 1'b1;
            tx_valid_r <= 1'b0;
            cyc_r      <= 1'b0;
            sel_r      <= 4'h0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            we_r       <= we_s;
            adr_r      <= adr_s;
            dat_r      <= dat_s;
            rdata_r    <= rdata_s;
            tmo_r      <= tmo_s;
            rsp_r      <= rsp_s;
            tx_data_r  <= tx_data_s;
            rx_ready_r <= (state_s == IDLE) || (state_s == ADDR) || (state_s == DATA);
            tx_valid_r <= (state_s == RESP) || (state_s == RDATA);
            cyc_r      <= (state_s == BUS);
            sel_r      <= (state_s == BUS) ? SEL_ALL : 4'h0;
            busy_r     <= (state_s != IDLE);
        end
    end

    assign rx_ready_o = rx_ready_r;
    assign tx_data_o  = tx_data_r;
    assign tx_valid_o = tx_valid_r;
    assign wb_adr_o   = adr_r;
    assign wb_dat_o   = dat_r;
    assign wb_sel_o   = sel_r;
    assign wb_we_o    = we_r;
    assign wb_cyc_o   = cyc_r;
    assign wb_stb_o   = cyc_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_wb_serial_master.sv
// ---------------------------------------------------------------------------
// tb_wb_serial_master
// Directed bench for the serial-to-Wishbone bridge. Expected response bytes
// are queued when a command is sent and compared as the bridge emits them.
// A small Wishbone slave model acks after a programmable number of wait
// cycles (or never) and records what each transfer looked like.
// ---------------------------------------------------------------------------
module tb_wb_serial_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    // Slave model configuration and observations.
    logic        ack_en = 1'b1;
    int          ack_wait = 0;
    int          cyc_cnt = 0;
    int          cyc_len = 0;
    logic [31:0] slave_rdata = 32'h0;
    logic [31:0] cap_adr = 32'h0, cap_dat = 32'h0;
    logic [3:0]  cap_sel = 4'h0;
    logic        cap_we = 1'b0;
    logic        we_seen = 1'b0;
    int          bus_err = 0;

    wb_serial_master #(.TIMEOUT_CYCLES(8), .SEL_ALL(4'hF)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
        .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
        .wb_ack_i(wb_ack), .wb_dat_i(wb_dat_i), .busy_o(busy)
    );

    always #5 clk = ~clk;

    assign wb_ack   = wb_cyc && ack_en && (cyc_cnt == ack_wait);
    assign wb_dat_i = slave_rdata;

    // Slave model: wait-cycle counter and transfer capture.
    always @(posedge clk) begin
        if (wb_cyc) begin
            cyc_cnt <= cyc_cnt + 1;
            cyc_len <= cyc_len + 1;
            if (wb_we) we_seen <= 1'b1;
            if (wb_stb !== wb_cyc || wb_sel !== 4'hF) bus_err <= bus_err + 1;
            if (wb_ack) begin
                cap_adr <= wb_adr;
                cap_dat <= wb_dat_o;
                cap_sel <= wb_sel;
                cap_we  <= wb_we;
            end
        end else begin
            cyc_cnt <= 0;
            if (wb_stb !== 1'b0 || wb_sel !== 4'h0) bus_err <= bus_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("rx_accept_timeout", 32'(t), 32'(0));
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] adr,
                            input logic [31:0] dat, input bit with_data);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(adr[31-8*i -: 8]);
        if (with_data) begin
            for (int i = 0; i < 4; i++) send_byte(dat[31-8*i -: 8]);
        end
    endtask

    task automatic recv_one();
        int t = 0;
        logic [7:0] e;
        while (!tx_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        e = exp_q.pop_front();
        chk("tx_byte", {24'h0, tx_data}, {24'h0, e});
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic recv_all();
        while (exp_q.size() > 0) recv_one();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
    endtask

    initial begin
        int t;
        int bp_bad;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        chk("rst_outputs", {tx_valid, wb_cyc, wb_stb, wb_we, busy, wb_sel},
                           32'h0);
        chk("rst_adr_dat", wb_adr | wb_dat_o | {24'h0, tx_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write with single-cycle ack.
        ack_en = 1'b1; ack_wait = 0; cyc_len = 0;
        send_cmd(8'h57, 32'h3000_0004, 32'hDEAD_BEEF, 1'b1);
        exp_q.push_back(8'h4B);
        recv_all();
        chk("wr_adr", cap_adr, 32'h3000_0004);
        chk("wr_dat", cap_dat, 32'hDEAD_BEEF);
        chk("wr_we_sel", {27'h0, cap_we, cap_sel}, {27'h0, 1'b1, 4'hF});
        chk("wr_cyc_len", 32'(cyc_len), 32'd1);
        chk("wr_idle", {30'h0, busy, rx_ready}, 32'h1);
        chk("wr_adr_hold", wb_adr, 32'h3000_0004);

        // Read with 3 wait cycles.
        ack_wait = 3; cyc_len = 0; we_seen = 1'b0; slave_rdata = 32'h1234_5678;
        send_cmd(8'h52, 32'h3080_0008, 32'h0, 1'b0);
        exp_q.push_back(8'h4B);
        push_word(32'h1234_5678);
        recv_all();
        chk("rd_adr", cap_adr, 32'h3080_0008);
        chk("rd_we_never", {31'h0, we_seen}, 32'h0);
        chk("rd_cyc_len", 32'(cyc_len), 32'd4);

        // Timeout: no ack at all.
        ack_en = 1'b0; cyc_len = 0;
        send_cmd(8'h52, 32'h4000_0000, 32'h0, 1'b0);
        exp_q.push_back(8'h54);
        recv_all();
        chk("tmo_cyc_len", 32'(cyc_len), 32'd8);
        repeat (5) @(negedge clk);
        chk("tmo_no_data", {31'h0, tx_valid}, 32'h0);
        chk("tmo_busy", {31'h0, busy}, 32'h0);

        // Ack arriving on the last allowed cycle wins.
        ack_en = 1'b1; ack_wait = 7; cyc_len = 0; slave_rdata = 32'hCAFE_F00D;
        send_cmd(8'h52, 32'h4000_0000, 32'h0, 1'b0);
        exp_q.push_back(8'h4B);
        push_word(32'hCAFE_F00D);
        recv_all();
        chk("tmo_ack_cyc_len", 32'(cyc_len), 32'd8);

        // Bad opcode, then a read parsed from the following byte.
        send_byte(8'h41);
        exp_q.push_back(8'h3F);
        recv_all();
        chk("bad_idle", {31'h0, busy}, 32'h0);
        ack_wait = 0; slave_rdata = 32'hA5A5_0F0F;
        send_cmd(8'h52, 32'h3000_0010, 32'h0, 1'b0);
        exp_q.push_back(8'h4B);
        push_word(32'hA5A5_0F0F);
        recv_all();
        chk("bad_then_rd_adr", cap_adr, 32'h3000_0010);

        // Backpressure on the read response; inbound bytes must stall.
        slave_rdata = 32'h0BAD_F00D;
        send_cmd(8'h52, 32'h3080_0000, 32'h0, 1'b0);
        exp_q.push_back(8'h4B);
        push_word(32'h0BAD_F00D);
        t = 0;
        while (!tx_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        bp_bad = 0;
        rx_data = 8'h57; rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h4B || rx_ready !== 1'b0) bp_bad++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("bp_stall", 32'(bp_bad), 32'd0);
        recv_all();
        chk("bp_idle", {30'h0, busy, rx_ready}, 32'h1);

        // Reset while the bus cycle is open.
        ack_en = 1'b0;
        send_cmd(8'h52, 32'h3000_0000, 32'h0, 1'b0);
        t = 0;
        while (!wb_cyc && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_cyc_seen", {31'h0, wb_cyc}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_async", {29'h0, wb_cyc, wb_stb, tx_valid}, 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_rx_ready", {30'h0, busy, rx_ready}, 32'h1);
        ack_en = 1'b1; ack_wait = 0; cyc_len = 0;
        send_cmd(8'h57, 32'h3000_0020, 32'h0102_0304, 1'b1);
        exp_q.push_back(8'h4B);
        recv_all();
        chk("rst_mid_wr_adr", cap_adr, 32'h3000_0020);
        chk("rst_mid_wr_dat", cap_dat, 32'h0102_0304);
        chk("rst_mid_wr_len", 32'(cyc_len), 32'd1);

        chk("bus_protocol", 32'(bus_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
